// File: rtl/img_pad.sv
// img_pad: copies a SRC_W x SRC_H image into a PAD-bordered region of one BRAM, edge-replicating the border.
// Optional macro IMG_PAD_ZERO_EN: write border pixels as 0 without a read (1 clock each).
`default_nettype none

module img_pad #(
  parameter int SRC_W    = 150,
  parameter int SRC_H    = 150,
  parameter int PAD      = 22,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 22500,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ren,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        din,
  input  logic [7:0]        dout
);

  localparam int PW = SRC_W + 2 * PAD;
  localparam int PH = SRC_H + 2 * PAD;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_W1   = 3'd2;
  localparam logic [2:0] S_W2   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        state;
  logic [8:0]        r, c;
  logic [7:0]        pix;

  logic signed [9:0] rs_raw, cs_raw, rs, cs;
  logic [ADDR_W-1:0] src, dst;
  logic [8:0]        nr, nc;
  logic              last;

`ifdef IMG_PAD_ZERO_EN
  function automatic logic is_border(input logic [8:0] rr, input logic [8:0] cc);
    return (rr < 9'(PAD)) || (rr >= 9'(PAD + SRC_H)) ||
           (cc < 9'(PAD)) || (cc >= 9'(PAD + SRC_W));
  endfunction
`endif

  assign rs_raw = $signed({1'b0, r}) - $signed(10'(PAD));
  assign cs_raw = $signed({1'b0, c}) - $signed(10'(PAD));

  // Clamp into the source image so the border replicates the nearest edge pixel.
  always_comb begin
    rs = rs_raw;
    cs = cs_raw;
    if (rs_raw < 0)
      rs = '0;
    else if (rs_raw > $signed(10'(SRC_H - 1)))
      rs = $signed(10'(SRC_H - 1));
    if (cs_raw < 0)
      cs = '0;
    else if (cs_raw > $signed(10'(SRC_W - 1)))
      cs = $signed(10'(SRC_W - 1));
  end

  assign src  = ADDR_W'(SRC_BASE) + ADDR_W'($unsigned(rs)) * ADDR_W'(SRC_W)
              + ADDR_W'($unsigned(cs));
  assign dst  = ADDR_W'(DST_BASE) + ADDR_W'(r) * ADDR_W'(PW) + ADDR_W'(c);
  assign last = (r == 9'(PH - 1)) && (c == 9'(PW - 1));
  assign nc   = (c == 9'(PW - 1)) ? 9'd0 : c + 9'd1;
  assign nr   = (c == 9'(PW - 1)) ? r + 9'd1 : r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      ren   <= 1'b0;
      wen   <= 1'b0;
      addr  <= '0;
      din   <= '0;
      r     <= '0;
      c     <= '0;
      pix   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ren <= 1'b0;
          wen <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            r    <= '0;
            c    <= '0;
`ifdef IMG_PAD_ZERO_EN
            state <= is_border(9'd0, 9'd0) ? S_WR : S_RD;
`else
            state <= S_RD;
`endif
          end
        end
        S_RD: begin
          wen   <= 1'b0;
          ren   <= 1'b1;
          addr  <= src;
          state <= S_W1;
        end
        S_W1: state <= S_W2;
        S_W2: begin
          ren   <= 1'b0;
          pix   <= dout;
          state <= S_WR;
        end
        S_WR: begin
          wen  <= 1'b1;
          addr <= dst;
`ifdef IMG_PAD_ZERO_EN
          din  <= is_border(r, c) ? 8'd0 : pix;
`else
          din  <= pix;
`endif
          if (last) begin
            state <= S_DONE;
          end else begin
            r <= nr;
            c <= nc;
`ifdef IMG_PAD_ZERO_EN
            state <= is_border(nr, nc) ? S_WR : S_RD;
`else
            state <= S_RD;
`endif
          end
        end
        S_DONE: begin
          wen  <= 1'b0;
          busy <= 1'b0;
          // done is raised on entry; only a low start seen while done is high releases it.
          if (done && !start) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_img_pad.sv
// tb_img_pad: randomized-image self-checking bench for img_pad on a reduced, non-square geometry.
`default_nettype none

module tb_img_pad;

  localparam int SRC_W    = 10;
  localparam int SRC_H    = 7;
  localparam int PAD      = 3;
  localparam int SRC_BASE = 5;
  localparam int DST_BASE = 200;
  localparam int ADDR_W   = 12;
  localparam int PW       = SRC_W + 2 * PAD;
  localparam int PH       = SRC_H + 2 * PAD;
  localparam int NPIX     = PW * PH;
  localparam int NSRC     = SRC_W * SRC_H;
`ifdef IMG_PAD_ZERO_EN
  localparam int EXP_LAT  = 4 * NSRC + (NPIX - NSRC) + 1;
`else
  localparam int EXP_LAT  = 4 * NPIX + 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy, done, ren, wen;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        din;
  logic [7:0]        dout;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] src_ref [0:NSRC-1];

  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int overlap_err = 0;
  int range_err   = 0;

  always #5 clk = ~clk;

  img_pad #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .PAD(PAD),
    .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ren(ren), .wen(wen), .addr(addr), .din(din), .dout(dout)
  );

  // Single-port BRAM: one-register read path.
  always @(posedge clk) begin
    if (wen) mem[addr] = din;
    if (ren) dout <= mem[addr];
  end

  always @(negedge clk) begin
    if (ren && wen) overlap_err++;
    if (wen) begin
      wr_cnt++;
      if (int'(addr) < DST_BASE || int'(addr) >= DST_BASE + NPIX) range_err++;
    end
    if (ren && (int'(addr) < SRC_BASE || int'(addr) >= SRC_BASE + NSRC)) range_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(input int r, input int c);
    int rs, cs;
    rs = r - PAD;
    cs = c - PAD;
    if (rs < 0) rs = 0;
    if (rs > SRC_H - 1) rs = SRC_H - 1;
    if (cs < 0) cs = 0;
    if (cs > SRC_W - 1) cs = SRC_W - 1;
`ifdef IMG_PAD_ZERO_EN
    if (r < PAD || r >= PAD + SRC_H || c < PAD || c >= PAD + SRC_W) return 8'd0;
`endif
    return src_ref[rs * SRC_W + cs];
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < NSRC; i++) begin
      src_ref[i] = 8'($urandom);
      mem[SRC_BASE + i] = src_ref[i];
    end
    for (int j = 0; j < NPIX; j++) mem[DST_BASE + j] = 8'($urandom);
  endtask

  task automatic run_copy(input bit toggle, output int lat);
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < EXP_LAT + 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 2) chk("busy_running", 32'(busy), 32'd1);
      if (toggle && lat == 10) start = 1'b0;
      if (toggle && lat == 14) start = 1'b1;
      if (done) break;
    end
  endtask

  task automatic check_result(input int lat, input int writes);
    int mism, smism;
    chk("done_latency", 32'(lat), 32'(EXP_LAT));
    chk("done_high", 32'(done), 32'd1);
    chk("busy_low_done", 32'(busy), 32'd0);
    chk("ren_low_done", 32'(ren), 32'd0);
    chk("wen_low_done", 32'(wen), 32'd0);
    chk("write_count", 32'(writes), 32'(NPIX));
    chk("corner_tl", 32'(mem[DST_BASE]), 32'(exp_pix(0, 0)));
    chk("corner_br", 32'(mem[DST_BASE + NPIX - 1]), 32'(exp_pix(PH - 1, PW - 1)));
    chk("interior_first", 32'(mem[DST_BASE + PAD * PW + PAD]), 32'(src_ref[0]));
    chk("left_edge", 32'(mem[DST_BASE + (PAD + 4) * PW]), 32'(exp_pix(PAD + 4, 0)));
    mism = 0;
    for (int r = 0; r < PH; r++)
      for (int c = 0; c < PW; c++)
        if (mem[DST_BASE + r * PW + c] !== exp_pix(r, c)) mism++;
    chk("image_mismatches", 32'(mism), 32'd0);
    smism = 0;
    for (int i = 0; i < NSRC; i++)
      if (mem[SRC_BASE + i] !== src_ref[i]) smism++;
    chk("source_intact", 32'(smism), 32'd0);
  endtask

  initial begin
    int lat, w0, w1;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ren", 32'(ren), 32'd0);
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    rst_n = 1'b1;
    fill_mem();
    @(posedge clk);
    #1;

    // First copy with start held high throughout.
    w0 = wr_cnt;
    run_copy(1'b0, lat);
    check_result(lat, wr_cnt - w0);

    // Held start must not retrigger.
    w1 = wr_cnt;
    repeat (30) @(posedge clk);
    #1;
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_no_writes", 32'(wr_cnt - w1), 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("done_cleared", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a copy.
    fill_mem();
    start = 1'b1;
    repeat (50) @(posedge clk);
    #3;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ren", 32'(ren), 32'd0);
    chk("arst_wen", 32'(wen), 32'd0);
    chk("arst_addr", 32'(addr), 32'd0);
    chk("arst_din", 32'(din), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w1 = wr_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_no_writes", 32'(wr_cnt - w1), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Rerun on a fresh image, wiggling start while busy.
    fill_mem();
    w0 = wr_cnt;
    run_copy(1'b1, lat);
    check_result(lat, wr_cnt - w0);

    chk("ren_wen_overlap", 32'(overlap_err), 32'd0);
    chk("addr_range", 32'(range_err), 32'd0);

    start = 1'b0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
